// File: rtl/ps2_key_event_queue_pkg.sv
// Shared constants, event layout and parser state encoding for the PS/2 key event queue.
package ps2_key_pkg;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  localparam logic [7:0] BYTE_BAT_OK = 8'hAA;
  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_ECHO   = 8'hEE;
  localparam logic [7:0] BYTE_ERR0   = 8'h00;
  localparam logic [7:0] BYTE_ERR1   = 8'hFF;
  localparam logic [7:0] BYTE_PAUSE  = 8'hE1;

  localparam int CODE_W  = 8;
  localparam int EV_W    = 10;
  localparam int EXT_BIT = 8;
  localparam int REL_BIT = 9;

  localparam int RD_PEND_BIT    = 10;
  localparam int RD_OVF_BIT     = 11;
  localparam int RD_EMPTY_N_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  // Controller chatter that never forms part of a key event.
  function automatic logic is_dropped(input logic [7:0] b);
    return (b == BYTE_BAT_OK) || (b == BYTE_ACK) || (b == BYTE_RESEND) ||
           (b == BYTE_ECHO) || (b == BYTE_ERR0) || (b == BYTE_ERR1) ||
           (b == BYTE_PAUSE);
  endfunction

  function automatic logic [EV_W-1:0] make_event(input logic rel, input logic ext,
                                                 input logic [CODE_W-1:0] code);
    return {rel, ext, code};
  endfunction

endpackage

// File: rtl/ps2_key_event_queue_if.sv
// Byte-input / event-output bundle of the PS/2 key event queue; slave is the queue itself.
interface ps2_key_event_queue_if #(parameter int DEPTH = 16);
  import ps2_key_pkg::*;

  // key_valid is a one-cycle qualifier for key_byte (no back-pressure);
  // rd_en pops the head each cycle it is high and is ignored when empty.
  logic                   key_valid;
  logic [7:0]             key_byte;
  logic                   rd_en;
  logic                   overflow_clr;
  logic [31:0]            rd_data;
  logic [$clog2(DEPTH):0] ev_count;
  state_t                 dbg_state;

  modport master (
    output key_valid, key_byte, rd_en, overflow_clr,
    input  rd_data, ev_count, dbg_state
  );

  modport slave (
    input  key_valid, key_byte, rd_en, overflow_clr,
    output rd_data, ev_count, dbg_state
  );

endinterface

// File: rtl/ps2_key_event_queue_sync_fifo.sv
// Synchronous FIFO with power-of-two depth; a pop on full makes room for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_ok = pop && !empty;
  assign wr_ok = push && (!full || rd_ok);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    end
  end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 scancode parser feeding an event FIFO read by the processor.
// Macro PS2_BREAK_EVENTS_EN: when defined, release (F0-prefixed) events are queued too.
module ps2_key_event_queue
  import ps2_key_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 500000
) (
  input logic                  clock,
  input logic                  reset,
  ps2_key_event_queue_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [TW-1:0]     timer;
  logic              push_q;
  logic [EV_W-1:0]   push_ev_q;
  logic              overflow;
  logic [EV_W-1:0]   head;
  logic [EV_W-1:0]   head_shown;
  logic              full;
  logic              empty;
  logic [$clog2(DEPTH):0] count;

  // Parser: completed events are registered once before entering the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      push_q    <= 1'b0;
      push_ev_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (bus.key_valid) begin
        timer <= '0;
        case (state)
          ST_IDLE: begin
            if (bus.key_byte == BYTE_E0) state <= ST_EXT;
            else if (bus.key_byte == BYTE_F0) state <= ST_BRK;
            else if (!is_dropped(bus.key_byte)) begin
              push_q    <= 1'b1;
              push_ev_q <= make_event(1'b0, 1'b0, bus.key_byte);
            end
          end
          ST_EXT: begin
            if (bus.key_byte == BYTE_F0) state <= ST_EXT_BRK;
            else if (bus.key_byte != BYTE_E0) begin
              push_q    <= 1'b1;
              push_ev_q <= make_event(1'b0, 1'b1, bus.key_byte);
              state     <= ST_IDLE;
            end
          end
          ST_BRK: begin
`ifdef PS2_BREAK_EVENTS_EN
            push_q    <= 1'b1;
            push_ev_q <= make_event(1'b1, 1'b0, bus.key_byte);
`endif
            state <= ST_IDLE;
          end
          default: begin
`ifdef PS2_BREAK_EVENTS_EN
            push_q    <= 1'b1;
            push_ev_q <= make_event(1'b1, 1'b1, bus.key_byte);
`endif
            state <= ST_IDLE;
          end
        endcase
      end else if (state != ST_IDLE) begin
        if (timer == TIMER_LAST) begin
          state <= ST_IDLE;
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  // Set wins over clear when both happen in one cycle.
  always_ff @(posedge clock) begin
    if (reset) overflow <= 1'b0;
    else if (push_q && full && !bus.rd_en) overflow <= 1'b1;
    else if (bus.overflow_clr) overflow <= 1'b0;
  end

  sync_fifo #(.WIDTH(EV_W), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_ev_q),
    .pop       (bus.rd_en),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    head_shown = empty ? '0 : head;
`ifndef PS2_BREAK_EVENTS_EN
    head_shown[REL_BIT] = 1'b0;
`endif
  end

  assign bus.rd_data   = {!empty, 19'b0, overflow, (state != ST_IDLE), head_shown};
  assign bus.ev_count  = count;
  assign bus.dbg_state = state;

endmodule
